wr_ctrl_burst: RTL and testbench
================================

WR_CTRL_BURST -- requirements
Module: wr_ctrl_burst

Interface
REQ-001 SHALL have parameter DATA_W, default 32, Avalon/FIFO data width in bits (multiple of 8; BYTES = DATA_W/8).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width of address, write_address, pkt_begin, pkt_end.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per burst (power of two, 1..256).
REQ-004 SHALL have parameter BURST_W, default 16, burstcount width.
REQ-005 SHALL have one clock and a synchronous, active-low reset, with ports as follows:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-low reset.
- wr_ctrl  in  1  level start request.
- control  in  32  reserved, ignored.
- pkt_begin  in  ADDR_W  packet start byte offset.
- pkt_end  in  ADDR_W  packet end byte offset (exclusive).
- write_address  in  ADDR_W  destination base byte address.
- fifo_out  in  DATA_W  show-ahead FIFO head word.
- empty  in  1  FIFO empty.
- rd_from_fifo  out  1  FIFO pop.
- wr_ctrl_rdy  out  1  idle/done indication.
- address  out  ADDR_W  Avalon burst address.
- writedata  out  DATA_W  Avalon write data.
- write  out  1  Avalon write.
- burstcount  out  BURST_W  Avalon burst length.
- waitrequest  in  1  Avalon slave stall.
- byteenable  out  BYTES  Avalon byte enables; present only with WR_CTRL_BYTEENABLE_EN.

Function
REQ-006 SHALL implement states IDLE, CALC, BURST, DONE.
REQ-007 IDLE: wr_ctrl_rdy=1; wr_ctrl=1 SHALL latch pkt_begin, pkt_end, write_address and go to CALC next cycle, dropping wr_ctrl_rdy.
REQ-008 CALC (1 cycle): words = ceil((pkt_end-pkt_begin)/BYTES); cur_addr = write_address with log2(BYTES) LSBs cleared. words=0 or pkt_end<=pkt_begin SHALL go to DONE with no write issued.
REQ-009 Burst length SHALL be min(MAX_BURST, remaining words, beats to next (MAX_BURST*BYTES)-aligned boundary of cur_addr); computed in CALC and after each burst's last beat.
REQ-010 BURST: write=1 only when empty=0; writedata=fifo_out; address=cur_addr and burstcount=burst length held constant for all beats of the burst.
REQ-011 A beat SHALL be accepted when write=1 and waitrequest=0; rd_from_fifo SHALL equal this acceptance, combinationally, exactly one pop per beat.
REQ-012 With waitrequest=1, write, writedata, address and burstcount SHALL hold; no pop.
REQ-013 With empty=1 mid-burst, write SHALL deassert (gap beat) without ending the burst; the burst resumes when empty=0.
REQ-014 After a burst's last beat: cur_addr += burst*BYTES and remaining -= burst; if remaining=0 go to DONE, else issue the next burst on the following cycle (one idle cycle between bursts).
REQ-015 DONE: wr_ctrl_rdy=1, write=0; stay until wr_ctrl=0, then go to IDLE (no restart while wr_ctrl is held high).
REQ-016 wr_ctrl deasserted mid-transfer SHALL be ignored; all issued bursts complete.
REQ-017 Address arithmetic SHALL wrap modulo 2^ADDR_W; burstcount SHALL be zero-extended to BURST_W.
REQ-018 control SHALL have no effect.

Reset
REQ-019 reset=0 at any rising clk edge SHALL force IDLE with write=0, rd_from_fifo=0, address=0, burstcount=0, writedata=0, wr_ctrl_rdy=0 during reset and 1 from the first cycle after release.
REQ-020 Reset mid-burst SHALL abandon the burst, with no further pops; FIFO contents are the caller's concern.

Configuration
REQ-021 With WR_CTRL_BYTEENABLE_EN defined: byteenable SHALL be all-ones on every beat except the packet's final beat, where only the low ((pkt_end-pkt_begin) mod BYTES) bytes are enabled (all-ones if remainder is 0). byteenable SHALL be 0 in reset/IDLE.
REQ-022 Without WR_CTRL_BYTEENABLE_EN: the byteenable port SHALL be absent and partial trailing words written whole.

Verification
REQ-023 Bench SHALL cover: DATA_W=32, pkt_end=32, write_address=0x8000, FIFO prefilled 10..17 -> one burst, burstcount=8, address=0x8000, writedata 10..17 in order, 8 pops, then wr_ctrl_rdy=1.
REQ-024 Bench SHALL cover: pkt_end=0 -> no write, no pop, wr_ctrl_rdy=1 within 2 cycles of start.
REQ-025 Bench SHALL cover: waitrequest=1 on beats 2 and 5 of an 8-beat burst -> data held, still exactly 8 pops, sequence 10..17 unbroken.
REQ-026 Bench SHALL cover: MAX_BURST=4, write_address=0x8008, 8 words -> bursts (0x8008,2),(0x8010,4),(0x8020,2).
REQ-027 Bench SHALL cover: FIFO empty for 3 cycles mid-burst -> write low for those cycles, burstcount unchanged, all data delivered.
REQ-028 Bench SHALL cover, with WR_CTRL_BYTEENABLE_EN: pkt_end=30 -> 8 beats, last beat byteenable=4'b0011, others 4'b1111.

Source files
------------

// File: rtl/wr_ctrl_burst.sv
// wr_ctrl_burst: moves a packet from a show-ahead FIFO to Avalon-MM as aligned write bursts.
// Optional trailing-word byte enables are built when WR_CTRL_BYTEENABLE_EN is defined.
//
// state | meaning
// IDLE  | ready, waiting for wr_ctrl
// CALC  | size the next burst (first pass also sizes the packet)
// BURST | issue the beats of the current burst
// DONE  | transfer finished, waiting for wr_ctrl to drop
module wr_ctrl_burst #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int BURST_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_ctrl,
  input  logic [31:0]        control,
  input  logic [ADDR_W-1:0]  pkt_begin,
  input  logic [ADDR_W-1:0]  pkt_end,
  input  logic [ADDR_W-1:0]  write_address,
  input  logic [DATA_W-1:0]  fifo_out,
  input  logic               empty,
  output logic               rd_from_fifo,
  output logic               wr_ctrl_rdy,
  output logic [ADDR_W-1:0]  address,
  output logic [DATA_W-1:0]  writedata,
  output logic               write,
  output logic [BURST_W-1:0] burstcount,
  input  logic               waitrequest
`ifdef WR_CTRL_BYTEENABLE_EN
  ,
  output logic [DATA_W/8-1:0] byteenable
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int LOG2B = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int LEN_W = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {IDLE, CALC, BURST, DONE} state_t;

  state_t            state;
  logic              first;
  logic [ADDR_W-1:0] begin_q, end_q, base_q;
  logic [ADDR_W-1:0] cur_addr, rem;
  logic [LEN_W-1:0]  len, beat_cnt;

  logic [ADDR_W-1:0] diff, words, aligned, calc_addr, calc_rem, off, btb, len_full;
  logic              empty_pkt, in_burst, accept, last_beat;
  logic              control_unused;

  assign control_unused = ^control;

  // Sizing path: the first CALC works from the latched packet, later ones from the running pointers.
  always_comb begin
    diff      = end_q - begin_q;
    words     = ADDR_W'(({1'b0, diff} + (ADDR_W+1)'(BYTES - 1)) >> LOG2B);
    aligned   = base_q & ~ADDR_W'(BYTES - 1);
    empty_pkt = (end_q <= begin_q);
    calc_addr = first ? aligned : cur_addr;
    calc_rem  = first ? words : rem;
    off       = (calc_addr >> LOG2B) & ADDR_W'(MAX_BURST - 1);
    btb       = ADDR_W'(MAX_BURST) - off;
    len_full  = (calc_rem < btb) ? calc_rem : btb;
  end

  assign in_burst     = (state == BURST) && reset;
  assign write        = in_burst && !empty;
  assign accept       = write && !waitrequest;
  assign rd_from_fifo = accept;
  assign writedata    = in_burst ? fifo_out : '0;
  assign wr_ctrl_rdy  = reset && ((state == IDLE) || (state == DONE));
  assign last_beat    = accept && (beat_cnt == LEN_W'(1));

`ifdef WR_CTRL_BYTEENABLE_EN
  logic [ADDR_W-1:0] tail_bytes;
  logic [BYTES-1:0]  tail_be;

  always_comb begin
    tail_bytes = diff & ADDR_W'(BYTES - 1);
    tail_be    = (tail_bytes == '0) ? '1 : ~({BYTES{1'b1}} << tail_bytes);
    byteenable = '0;
    if (in_burst)
      byteenable = ((beat_cnt == LEN_W'(1)) && (rem == ADDR_W'(len))) ? tail_be : '1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      first      <= 1'b0;
      begin_q    <= '0;
      end_q      <= '0;
      base_q     <= '0;
      cur_addr   <= '0;
      rem        <= '0;
      len        <= '0;
      beat_cnt   <= '0;
      address    <= '0;
      burstcount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_ctrl) begin
            begin_q <= pkt_begin;
            end_q   <= pkt_end;
            base_q  <= write_address;
            first   <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          first <= 1'b0;
          if ((first && empty_pkt) || (calc_rem == '0)) begin
            state <= DONE;
          end else begin
            cur_addr   <= calc_addr;
            rem        <= calc_rem;
            len        <= LEN_W'(len_full);
            beat_cnt   <= LEN_W'(len_full);
            address    <= calc_addr;
            burstcount <= BURST_W'(LEN_W'(len_full));
            state      <= BURST;
          end
        end
        BURST: begin
          if (last_beat) begin
            cur_addr <= cur_addr + (ADDR_W'(len) << LOG2B);
            rem      <= rem - ADDR_W'(len);
            state    <= (rem == ADDR_W'(len)) ? DONE : CALC;
          end else if (accept) begin
            beat_cnt <= beat_cnt - LEN_W'(1);
          end
        end
        DONE: begin
          if (!wr_ctrl) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wr_ctrl_burst.sv
// Bench for wr_ctrl_burst: directed scenarios plus randomized packets against a burst-splitting model.
module tb_wr_ctrl_burst;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, wr_ctrl, waitrequest, gap, sel, empty;
  logic [31:0] control, pkt_begin, pkt_end, write_address, fifo_out;
  logic        wr_a, wr_b;

  logic [31:0] fifo_mem [0:255];
  logic [7:0]  rd_ptr = 8'd0;
  logic [7:0]  wr_ptr;

  logic        a_rd, a_rdy, a_write, b_rd, b_rdy, b_write;
  logic [31:0] a_addr, a_data, b_addr, b_data;
  logic [15:0] a_bc, b_bc;
  logic        m_rd, m_rdy, m_write;
  logic [31:0] m_addr, m_data;
  logic [15:0] m_bc;
`ifdef WR_CTRL_BYTEENABLE_EN
  logic [3:0]  a_be, b_be, m_be;
  assign m_be = sel ? b_be : a_be;
`endif

  assign fifo_out = fifo_mem[rd_ptr];
  assign empty    = (rd_ptr == wr_ptr) || gap;
  assign wr_a     = wr_ctrl && !sel;
  assign wr_b     = wr_ctrl && sel;
  assign m_rd     = sel ? b_rd : a_rd;
  assign m_rdy    = sel ? b_rdy : a_rdy;
  assign m_write  = sel ? b_write : a_write;
  assign m_addr   = sel ? b_addr : a_addr;
  assign m_data   = sel ? b_data : a_data;
  assign m_bc     = sel ? b_bc : a_bc;

  always @(posedge clk) if (m_rd) rd_ptr <= rd_ptr + 8'd1;

  wr_ctrl_burst #(.DATA_W(32), .ADDR_W(32), .MAX_BURST(16), .BURST_W(16)) dut_a (
    .clk(clk), .reset(reset), .wr_ctrl(wr_a), .control(control),
    .pkt_begin(pkt_begin), .pkt_end(pkt_end), .write_address(write_address),
    .fifo_out(fifo_out), .empty(empty), .rd_from_fifo(a_rd), .wr_ctrl_rdy(a_rdy),
    .address(a_addr), .writedata(a_data), .write(a_write), .burstcount(a_bc),
    .waitrequest(waitrequest)
`ifdef WR_CTRL_BYTEENABLE_EN
    , .byteenable(a_be)
`endif
  );

  wr_ctrl_burst #(.DATA_W(32), .ADDR_W(32), .MAX_BURST(4), .BURST_W(16)) dut_b (
    .clk(clk), .reset(reset), .wr_ctrl(wr_b), .control(control),
    .pkt_begin(pkt_begin), .pkt_end(pkt_end), .write_address(write_address),
    .fifo_out(fifo_out), .empty(empty), .rd_from_fifo(b_rd), .wr_ctrl_rdy(b_rdy),
    .address(b_addr), .writedata(b_data), .write(b_write), .burstcount(b_bc),
    .waitrequest(waitrequest)
`ifdef WR_CTRL_BYTEENABLE_EN
    , .byteenable(b_be)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] q_addr[$], q_data[$];
  logic [15:0] q_bc[$];
  logic [3:0]  q_be[$];
  logic [31:0] e_addr[$], exp_data[$];
  int          e_bc[$];
  int          pops, rd_err, hold_err, gap_err, stall_cnt, gap_cycles, done_cyc;
  bit          timed_out;

  task automatic flush();
    wr_ptr = rd_ptr;
    exp_data.delete();
  endtask

  task automatic push(input logic [31:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
    exp_data.push_back(d);
  endtask

  // Expected beats from the splitting rule: min(max burst, words left, beats to the next aligned window).
  task automatic model(input logic [31:0] pb, input logic [31:0] pe, input logic [31:0] wa, input int mb);
    longint      words;
    logic [31:0] a;
    int          lim, n;
    e_addr.delete();
    e_bc.delete();
    if (pe > pb) begin
      words = (longint'(pe) - longint'(pb) + 3) / 4;
      a = wa & 32'hFFFF_FFFC;
      while (words > 0) begin
        lim = mb - int'((a / 4) % mb);
        n = mb;
        if (words < n) n = int'(words);
        if (lim < n) n = lim;
        for (int k = 0; k < n; k++) begin
          e_addr.push_back(a);
          e_bc.push_back(n);
        end
        a = a + 32'(n * 4);
        words -= n;
      end
    end
  endtask

  task automatic do_xfer(input bit s, input logic [31:0] pb, input logic [31:0] pe, input logic [31:0] wa,
                         input bit rnd, input logic [15:0] stall_mask, input int gap_at,
                         input int hold_extra, input bit drop_early);
    int          cyc, nbeat, gap_left;
    logic [15:0] stalled;
    bit          gap_done, done, pv_stall;
    logic [31:0] pv_addr, pv_data;
    logic [15:0] pv_bc;
    q_addr.delete(); q_data.delete(); q_bc.delete(); q_be.delete();
    pops = 0; rd_err = 0; hold_err = 0; gap_err = 0; stall_cnt = 0; gap_cycles = 0;
    done_cyc = -1; timed_out = 0;
    sel = s; pkt_begin = pb; pkt_end = pe; write_address = wa;
    cyc = 0; nbeat = 0; gap_left = 0; stalled = '0; gap_done = 0; done = 0; pv_stall = 0;
    pv_addr = '0; pv_data = '0; pv_bc = '0;
    while (!done) begin
      @(negedge clk);
      wr_ctrl = !(drop_early && cyc >= 3);
      control = $urandom;
      waitrequest = 1'b0;
      gap = 1'b0;
      if (rnd) begin
        waitrequest = ($urandom_range(0, 3) == 0);
        gap = !pv_stall && ($urandom_range(0, 5) == 0);
      end else begin
        if (nbeat < 16 && stall_mask[nbeat] && !stalled[nbeat]) waitrequest = 1'b1;
        if (gap_at == nbeat && !gap_done) begin gap_left = 3; gap_done = 1; end
        if (gap_left > 0) begin gap = 1'b1; gap_left--; end
      end
      #1;
      if (m_rd !== (m_write && !waitrequest)) rd_err++;
      if (gap) gap_cycles++;
      if (gap && m_write) gap_err++;
      if (!rnd && gap && q_bc.size() > 0 && m_bc !== q_bc[$]) gap_err++;
      if (pv_stall && (m_write !== 1'b1 || m_addr !== pv_addr || m_data !== pv_data || m_bc !== pv_bc))
        hold_err++;
      pv_stall = m_write && waitrequest;
      pv_addr = m_addr; pv_data = m_data; pv_bc = m_bc;
      if (m_write && waitrequest) begin
        stall_cnt++;
        if (nbeat < 16) stalled[nbeat] = 1'b1;
      end
      if (m_rd) pops++;
      if (m_write && !waitrequest) begin
        q_addr.push_back(m_addr); q_data.push_back(m_data); q_bc.push_back(m_bc);
`ifdef WR_CTRL_BYTEENABLE_EN
        q_be.push_back(m_be);
`endif
        nbeat++;
      end
      if (cyc >= 1 && m_rdy) begin done = 1; done_cyc = cyc; end
      cyc++;
      if (cyc > 500) begin timed_out = 1; done = 1; end
    end
    waitrequest = 1'b0;
    gap = 1'b0;
    // wr_ctrl stays high here: the block must sit in DONE without restarting
    repeat (hold_extra) begin
      @(negedge clk); #1;
      if (m_write || !m_rdy) hold_err++;
    end
    @(negedge clk);
    wr_ctrl = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_ctrl = 1'b0; waitrequest = 1'b0; gap = 1'b0; sel = 1'b0;
    control = '0; pkt_begin = '0; pkt_end = '0; write_address = '0;
    wr_ptr = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (a_write !== 1'b0) begin failures++; $display("FAIL rst_write got %b expected 0", a_write); end
    checks++; if (a_rd !== 1'b0) begin failures++; $display("FAIL rst_rd got %b expected 0", a_rd); end
    checks++; if (a_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got %h expected 0", a_addr); end
    checks++; if (a_bc !== 16'h0) begin failures++; $display("FAIL rst_bc got %h expected 0", a_bc); end
    checks++; if (a_data !== 32'h0) begin failures++; $display("FAIL rst_data got %h expected 0", a_data); end
    checks++; if (a_rdy !== 1'b0) begin failures++; $display("FAIL rst_rdy got %b expected 0", a_rdy); end
`ifdef WR_CTRL_BYTEENABLE_EN
    checks++; if (a_be !== 4'h0) begin failures++; $display("FAIL rst_be got %h expected 0", a_be); end
`endif
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1)
      begin failures++; $display("FAIL rel_rdy got %b%b expected 11", a_rdy, b_rdy); end
  endtask

  task automatic test_single_burst();
    int bad;
    flush();
    for (int i = 0; i < 8; i++) push(32'(10 + i));
    do_xfer(1'b0, 32'd0, 32'd32, 32'h8000, 1'b0, 16'h0, -1, 3, 1'b0);
    checks++; if (timed_out) begin failures++; $display("FAIL single_timeout got 1 expected 0"); end
    checks++; if (q_data.size() != 8) begin failures++; $display("FAIL single_beats got %0d expected 8", q_data.size()); end
    bad = 0;
    for (int i = 0; i < q_data.size(); i++)
      if (q_addr[i] !== 32'h8000 || q_bc[i] !== 16'd8 || q_data[i] !== 32'(10 + i)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL single_beat_fields got %0d bad expected 0", bad); end
    checks++; if (pops != 8) begin failures++; $display("FAIL single_pops got %0d expected 8", pops); end
    checks++; if (rd_err != 0) begin failures++; $display("FAIL single_rd_vs_accept got %0d expected 0", rd_err); end
    checks++; if (hold_err != 0) begin failures++; $display("FAIL single_done_hold got %0d expected 0", hold_err); end
  endtask

  task automatic test_empty_pkt();
    flush();
    do_xfer(1'b0, 32'd0, 32'd0, 32'h8000, 1'b0, 16'h0, -1, 0, 1'b0);
    checks++; if (q_data.size() != 0 || pops != 0)
      begin failures++; $display("FAIL empty_no_write got beats=%0d pops=%0d expected 0 0", q_data.size(), pops); end
    checks++; if (done_cyc < 1 || done_cyc > 2)
      begin failures++; $display("FAIL empty_rdy_latency got %0d expected 1..2", done_cyc); end
    do_xfer(1'b1, 32'd40, 32'd8, 32'h100, 1'b0, 16'h0, -1, 0, 1'b0);
    checks++; if (q_data.size() != 0 || pops != 0)
      begin failures++; $display("FAIL neg_no_write got beats=%0d pops=%0d expected 0 0", q_data.size(), pops); end
    checks++; if (done_cyc < 1 || done_cyc > 2)
      begin failures++; $display("FAIL neg_rdy_latency got %0d expected 1..2", done_cyc); end
  endtask

  task automatic test_waitrequest();
    int bad;
    flush();
    for (int i = 0; i < 8; i++) push(32'(10 + i));
    do_xfer(1'b0, 32'd0, 32'd32, 32'h8000, 1'b0, 16'b0000_0000_0001_0010, -1, 0, 1'b0);
    checks++; if (stall_cnt != 2) begin failures++; $display("FAIL wait_stalls got %0d expected 2", stall_cnt); end
    checks++; if (hold_err != 0) begin failures++; $display("FAIL wait_hold got %0d expected 0", hold_err); end
    checks++; if (pops != 8) begin failures++; $display("FAIL wait_pops got %0d expected 8", pops); end
    bad = (q_data.size() == 8) ? 0 : 1;
    for (int i = 0; i < q_data.size(); i++) if (q_data[i] !== 32'(10 + i)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL wait_sequence got %0d bad expected 0", bad); end
    checks++; if (rd_err != 0) begin failures++; $display("FAIL wait_rd_vs_accept got %0d expected 0", rd_err); end
  endtask

  task automatic test_boundary();
    logic [31:0] ea [8];
    logic [15:0] eb [8];
    int bad;
    ea = '{32'h8008, 32'h8008, 32'h8010, 32'h8010, 32'h8010, 32'h8010, 32'h8020, 32'h8020};
    eb = '{16'd2, 16'd2, 16'd4, 16'd4, 16'd4, 16'd4, 16'd2, 16'd2};
    flush();
    for (int i = 0; i < 8; i++) push(32'(100 + i));
    do_xfer(1'b1, 32'd0, 32'd32, 32'h8008, 1'b0, 16'h0, -1, 0, 1'b0);
    checks++; if (q_data.size() != 8) begin failures++; $display("FAIL bound_beats got %0d expected 8", q_data.size()); end
    bad = 0;
    for (int i = 0; i < q_data.size() && i < 8; i++)
      if (q_addr[i] !== ea[i] || q_bc[i] !== eb[i] || q_data[i] !== 32'(100 + i)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL bound_bursts got %0d bad expected 0", bad); end
    checks++; if (pops != 8) begin failures++; $display("FAIL bound_pops got %0d expected 8", pops); end
  endtask

  task automatic test_gap();
    int bad;
    flush();
    for (int i = 0; i < 8; i++) push(32'(10 + i));
    do_xfer(1'b0, 32'd0, 32'd32, 32'h8000, 1'b0, 16'h0, 3, 0, 1'b0);
    checks++; if (gap_cycles != 3) begin failures++; $display("FAIL gap_cycles got %0d expected 3", gap_cycles); end
    checks++; if (gap_err != 0) begin failures++; $display("FAIL gap_write_or_bc got %0d expected 0", gap_err); end
    bad = (q_data.size() == 8) ? 0 : 1;
    for (int i = 0; i < q_data.size(); i++) if (q_data[i] !== 32'(10 + i) || q_bc[i] !== 16'd8) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL gap_delivery got %0d bad expected 0", bad); end
    checks++; if (pops != 8) begin failures++; $display("FAIL gap_pops got %0d expected 8", pops); end
  endtask

`ifdef WR_CTRL_BYTEENABLE_EN
  task automatic test_byteenable();
    int bad;
    flush();
    for (int i = 0; i < 8; i++) push(32'(10 + i));
    do_xfer(1'b0, 32'd0, 32'd30, 32'h8000, 1'b0, 16'h0, -1, 0, 1'b0);
    checks++; if (q_be.size() != 8) begin failures++; $display("FAIL be_beats got %0d expected 8", q_be.size()); end
    bad = 0;
    for (int i = 0; i < q_be.size(); i++) if (q_be[i] !== ((i == 7) ? 4'b0011 : 4'b1111)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL be_pattern got %0d bad expected 0", bad); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] start, snap;
    int guard;
    flush();
    for (int i = 0; i < 16; i++) push(32'(200 + i));
    sel = 1'b0; pkt_begin = '0; pkt_end = 32'd64; write_address = '0;
    waitrequest = 1'b0; gap = 1'b0;
    start = rd_ptr;
    @(negedge clk);
    wr_ctrl = 1'b1;
    guard = 0;
    while (8'(rd_ptr - start) < 8'd3 && guard < 50) begin @(negedge clk); guard++; end
    checks++; if (guard >= 50) begin failures++; $display("FAIL midrst_start got timeout expected 3 pops"); end
    reset = 1'b0;
    waitrequest = 1'b1;
    snap = rd_ptr;
    @(negedge clk); #1;
    checks++; if (a_write !== 1'b0 || a_rd !== 1'b0 || a_addr !== 32'h0 || a_bc !== 16'h0)
      begin failures++; $display("FAIL midrst_outputs got w=%b rd=%b a=%h bc=%h expected 0", a_write, a_rd, a_addr, a_bc); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wr_ctrl = 1'b0;
    waitrequest = 1'b0;
    @(negedge clk); #1;
    checks++; if (a_rdy !== 1'b1 || a_write !== 1'b0)
      begin failures++; $display("FAIL midrst_idle got rdy=%b w=%b expected 1 0", a_rdy, a_write); end
    @(negedge clk);
    checks++; if (rd_ptr !== snap) begin failures++; $display("FAIL midrst_pops got %0d expected %0d", rd_ptr, snap); end
    flush();
  endtask

  task automatic test_random();
    logic [31:0] pb, pe, wa;
    int len, nwords, bad, mb;
    bit s;
    logic [3:0] ebe;
    for (int it = 0; it < 25; it++) begin
      s = $urandom_range(0, 1) == 1;
      mb = s ? 4 : 16;
      pb = $urandom_range(0, 64);
      len = $urandom_range(0, 100);
      pe = ($urandom_range(0, 7) == 0) ? (pb >> 1) : pb + 32'(len);
      wa = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63))) : $urandom;
      nwords = (pe > pb) ? int'((pe - pb + 3) / 4) : 0;
      flush();
      for (int i = 0; i < nwords; i++) push($urandom);
      model(pb, pe, wa, mb);
      do_xfer(s, pb, pe, wa, 1'b1, 16'h0, -1, $urandom_range(0, 2), $urandom_range(0, 1) == 1);
      checks++; if (timed_out) begin failures++; $display("FAIL rnd_timeout it=%0d got 1 expected 0", it); end
      checks++; if (q_data.size() != e_addr.size())
        begin failures++; $display("FAIL rnd_beats it=%0d got %0d expected %0d", it, q_data.size(), e_addr.size()); end
      bad = 0;
      for (int i = 0; i < q_data.size() && i < e_addr.size(); i++) begin
        if (q_addr[i] !== e_addr[i] || q_bc[i] !== 16'(e_bc[i]) || q_data[i] !== exp_data[i]) bad++;
`ifdef WR_CTRL_BYTEENABLE_EN
        ebe = ((pe - pb) % 4 == 0) ? 4'hF : ~(4'hF << ((pe - pb) % 4));
        if (q_be[i] !== ((i == e_addr.size() - 1) ? ebe : 4'hF)) bad++;
`else
        ebe = 4'hF;
`endif
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL rnd_beat_fields it=%0d got %0d bad expected 0", it, bad); end
      checks++; if (pops != nwords) begin failures++; $display("FAIL rnd_pops it=%0d got %0d expected %0d", it, pops, nwords); end
      checks++; if (rd_err + hold_err + gap_err != 0)
        begin failures++; $display("FAIL rnd_protocol it=%0d got rd=%0d hold=%0d gap=%0d expected 0", it, rd_err, hold_err, gap_err); end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_empty_pkt();
    test_waitrequest();
    test_boundary();
    test_gap();
`ifdef WR_CTRL_BYTEENABLE_EN
    test_byteenable();
`endif
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
